spi_slave_rx: RTL

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_slave_rx_if.sv | 30 +++
 rtl/spi_slave_rx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_if.sv
// Parallel side of the SPI slave: byte to return, received byte, event pulses.
// Latency: n/a (signal bundle only).
// Backpressure: none; the SPI master paces every transfer.
//
// Ports (modports):
//   slave  - the SPI block: reads tx_data, drives tx_load/rx_data/rx_valid/frame_err
//   master - the host logic: drives tx_data, observes the rest
interface spi_slave_rx_if;
  logic [7:0] tx_data;
  logic       tx_load;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;

  modport slave (
    input  tx_data,
    output tx_load,
    output rx_data,
    output rx_valid,
    output frame_err
  );

  modport master (
    output tx_data,
    input  tx_load,
    input  rx_data,
    input  rx_valid,
    input  frame_err
  );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI slave (modes 0-3) oversampled by clk: receives MOSI bytes, returns MISO bytes.
// Latency: rx_valid/tx_load one clk after the synchronized 8th sample edge (SYNC_STAGES+1 after sclk).
// Backpressure: none; rx_valid is a one-cycle pulse and rx_data simply holds until the next byte.
//
// Ports:
//   clk, reset        - system clock, synchronous active-high reset
//   polarity, phase   - CPOL/CPHA, latched when a frame starts
//   sclk, cs_n, mosi  - asynchronous SPI inputs (synchronized here)
//   miso, miso_oe     - SPI data out and its drive enable (high only inside a frame)
//   bus               - parallel side: tx_data/tx_load, rx_data/rx_valid, frame_err
module spi_slave_rx #(
  parameter int SYNC_STAGES = 2  // legal range 2..3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            polarity,
  input  logic            phase,
  input  logic            sclk,
  input  logic            cs_n,
  input  logic            mosi,
  output logic            miso,
  output logic            miso_oe,
  spi_slave_rx_if.slave   bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Synchronizers and one-cycle-delayed copies for edge detection
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      // Load idle levels so releasing reset never looks like an edge
      sclk_sync <= {SYNC_STAGES{polarity}};
      cs_sync   <= {SYNC_STAGES{1'b1}};
      mosi_sync <= '0;
      sclk_d    <= polarity;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  // Frame state and datapath registers
  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  // Only 7 bits are kept: the 8th sampled bit goes straight into rx_data.
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       cpol_q, cpol_d;
  logic       cpha_q, cpha_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_load_q, tx_load_d;
  logic       frame_err_q, frame_err_d;

  logic cs_fall;
  logic cs_rise;
  logic lead_edge;
  logic trail_edge;
  logic sample_edge;
  logic shift_edge;

  assign cs_fall     = cs_d & ~cs_s;
  assign cs_rise     = ~cs_d & cs_s;
  // Leading edge leaves the latched idle level, trailing edge returns to it
  assign lead_edge   = (sclk_d == cpol_q) && (sclk_s != cpol_q);
  assign trail_edge  = (sclk_d != cpol_q) && (sclk_s == cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge  : trail_edge;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    rx_valid_d  = 1'b0;
    tx_load_d   = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = ACTIVE;
          bit_cnt_d  = 3'd0;
          rx_shift_d = '0;
          tx_shift_d = bus.tx_data;
          tx_load_d  = 1'b1;
          cpol_d     = polarity;
          cpha_d     = phase;
        end
      end

      ACTIVE: begin
        // cs_n release takes priority over any sclk edge seen in the same cycle
        if (cs_rise) begin
          state_d     = IDLE;
          bit_cnt_d   = 3'd0;
          rx_shift_d  = '0;
          tx_shift_d  = '0;
          frame_err_d = (bit_cnt_q != 3'd0);
        end else if (sample_edge) begin
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = {rx_shift_q, mosi_s};
            rx_valid_d = 1'b1;
            rx_shift_d = '0;
            bit_cnt_d  = 3'd0;
            tx_shift_d = bus.tx_data;
            tx_load_d  = 1'b1;
          end else begin
            rx_shift_d = {rx_shift_q[5:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
          end
        end else if (shift_edge && (bit_cnt_q != 3'd0)) begin
          // With bit_cnt 0 the shift edge is either the first leading edge
          // (CPHA=1) or the edge right after a reload (CPHA=0); in both cases
          // bit 7 must stay on miso, so only later shift edges advance.
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_load_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      rx_valid_q  <= rx_valid_d;
      tx_load_q   <= tx_load_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign miso_oe       = (state_q == ACTIVE);
  assign miso          = miso_oe & tx_shift_q[7];
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.tx_load   = tx_load_q;
  assign bus.frame_err = frame_err_q;

endmodule
